// File: rtl/bram_uart_sender_pkg.sv
// Shared constants for the frame-dump path: main FSM state codes, BRAM geometry
// and the sender's own sequencing states.
package bram_uart_sender_pkg;

  localparam logic [2:0] FSM_IDLE     = 3'd0;
  localparam logic [2:0] SEL_BKGD     = 3'd1;
  localparam logic [2:0] COLOR_EDITS  = 3'd2;
  localparam logic [2:0] ADD_EDITS    = 3'd3;
  localparam logic [2:0] SAVE_TO_BRAM = 3'd4;
  localparam logic [2:0] SEND_TO_PC   = 3'd5;

  localparam int BRAM_ADDR_W = 17;
  localparam int PIX_W       = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_HI,
    S_LO,
    S_CK,
    S_DONE
  } tx_state_e;

endpackage

// File: rtl/bram_uart_sender_uart_tx_byte.sv
// 8N1 byte serializer: one start bit, eight data bits LSB first, one stop bit,
// each held BAUD_DIV clocks. A new byte may be accepted on the byte_done cycle.
module uart_tx_byte #(
  parameter int BAUD_DIV = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bits_q, bits_d;
  logic [8:0]       shift_q, shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
    end else begin
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    busy_d    = busy_q;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    ready     = !busy_q;
    byte_done = busy_q && (cnt_q == '0) && (bits_q == 4'd0);

    if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (bits_q == 4'd0) begin
        busy_d = 1'b0;
      end else begin
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
        bits_d  = bits_q - 4'd1;
        cnt_d   = CNT_W'(BAUD_DIV - 1);
      end
    end

    // shift holds the eight data bits followed by the stop bit
    if (start && (ready || byte_done)) begin
      busy_d  = 1'b1;
      tx_d    = 1'b0;
      shift_d = {1'b1, data};
      bits_d  = 4'd9;
      cnt_d   = CNT_W'(BAUD_DIV - 1);
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/bram_uart_sender.sv
// Streams the saved frame from BRAM to the PC on entry to SEND_TO_PC, two bytes
// per 12-bit pixel. Define TX_CHECKSUM_EN to append an XOR checksum byte.
module bram_uart_sender
  import bram_uart_sender_pkg::*;
#(
  parameter int ADDR_W    = BRAM_ADDR_W,
  parameter int NUM_WORDS = 76800,
  parameter int BAUD_DIV  = 564
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        fsm_state,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [PIX_W-1:0]  bram_dout,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  word_q, word_d;
  logic              in5_q, pend_q, pend_d, abort_q, abort_d;
  logic              in5, edge_5, stop_req, last_word;
  logic              tx_start, tx_ready, tx_done;
  logic [7:0]        tx_data;
`ifdef TX_CHECKSUM_EN
  logic [7:0]        ck_q, ck_d;
`endif

  assign in5       = (fsm_state == SEND_TO_PC);
  assign edge_5    = in5 && !in5_q;
  assign stop_req  = abort_q || !in5;
  assign last_word = (addr_q == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      in5_q   <= 1'b0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef TX_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      in5_q   <= in5;
      pend_q  <= pend_d;
      abort_q <= abort_d;
`ifdef TX_CHECKSUM_EN
      ck_q    <= ck_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    abort_d  = abort_q;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    // an entry edge seen while draining an aborted byte is kept for later
    pend_d   = in5 && (pend_q || edge_5);
`ifdef TX_CHECKSUM_EN
    ck_d     = ck_q;
`endif
    if (!in5 && state_q != S_IDLE && state_q != S_DONE) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (in5 && (edge_5 || pend_q)) begin
          pend_d  = 1'b0;
          addr_d  = '0;
          state_d = S_READ;
`ifdef TX_CHECKSUM_EN
          ck_d    = '0;
`endif
        end
      end
      S_READ: state_d = stop_req ? S_IDLE : S_LOAD;
      S_LOAD: begin
        word_d  = bram_dout;
        state_d = stop_req ? S_IDLE : S_HI;
      end
      S_HI: begin
        if (tx_ready) begin
          if (stop_req) state_d = S_IDLE;
          else begin
            tx_start = 1'b1;
            tx_data  = {4'b0000, word_q[11:8]};
          end
        end else if (tx_done) begin
          if (stop_req) state_d = S_IDLE;
          else begin
            tx_start = 1'b1;
            tx_data  = word_q[7:0];
            state_d  = S_LO;
          end
        end
      end
      S_LO: begin
        if (tx_done) begin
          if (stop_req) state_d = S_IDLE;
          else if (last_word) begin
`ifdef TX_CHECKSUM_EN
            tx_start = 1'b1;
            tx_data  = ck_q;
            state_d  = S_CK;
`else
            state_d  = S_DONE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
`ifdef TX_CHECKSUM_EN
      S_CK: if (tx_done) state_d = stop_req ? S_IDLE : S_DONE;
`endif
      S_DONE: if (!in5) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef TX_CHECKSUM_EN
    if (tx_start) ck_d = ck_q ^ tx_data;
`endif
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (tx_start),
    .data      (tx_data),
    .tx        (uart_tx),
    .ready     (tx_ready),
    .byte_done (tx_done)
  );

  assign bram_addr = addr_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_bram_uart_sender.sv
// Directed/randomized bench for bram_uart_sender with a byte-level reference model
// and a UART line decoder.
module tb_bram_uart_sender;

  localparam int NW = 3;
  localparam int BD = 4;

  logic        clk, rst;
  logic [2:0]  fsm_state;
  logic [16:0] bram_addr;
  logic [11:0] bram_dout;
  logic        uart_tx, busy, done;

  logic [11:0] mem [0:NW-1];
  logic [7:0]  exp_q [$];
  int          n_pass, n_total;

  bram_uart_sender #(.ADDR_W(17), .NUM_WORDS(NW), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .fsm_state(fsm_state), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    bram_dout <= (bram_addr < 17'(NW)) ? mem[bram_addr[1:0]] : 12'h000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    assert (got === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
  endtask

  // Expected byte stream derived from the BRAM contents.
  task automatic build_exp();
    logic [7:0] x;
    exp_q.delete();
    x = 8'h00;
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back({4'h0, mem[i][11:8]});
      exp_q.push_back(mem[i][7:0]);
      x = x ^ {4'h0, mem[i][11:8]} ^ mem[i][7:0];
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Decodes one frame; returns at the negedge inside the last stop-bit cycle.
  task automatic rx_byte(input int abort_at, output logic [7:0] b, output int idle, output bit ok);
    logic first, v;
    idle = 0; ok = 1'b1; b = 8'h00; first = 1'b0;
    while (1) begin
      @(negedge clk);
      if (uart_tx === 1'b0) break;
      idle++;
      if (idle > 300) begin
        ok = 1'b0;
        return;
      end
    end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < BD; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (k * BD + c == abort_at) fsm_state = 3'd0;
        v = uart_tx;
        if (c == 0) first = v;
        else if (v !== first) ok = 1'b0;
      end
      if (k == 0 && first !== 1'b0) ok = 1'b0;
      if (k >= 1 && k <= 8) b[k-1] = first;
      if (k == 9 && first !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic do_xfer(input string tag, input int nbytes, input int abort_idx);
    logic [7:0] b;
    int idle, exp_idle;
    bit ok;
    build_exp();
    for (int i = 0; i < nbytes && i < exp_q.size(); i++) begin
      rx_byte((i == abort_idx) ? 5 * BD : -1, b, idle, ok);
      exp_idle = (i == 0) ? 3 : ((i % 2 == 1) || (i == 2 * NW)) ? 0 : 3;
      chk($sformatf("%s_frame%0d", tag, i), 32'(ok), 32'd1);
      chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_q[i]));
      chk($sformatf("%s_gap%0d", tag, i), 32'(idle), 32'(exp_idle));
    end
  endtask

  task automatic end_of_xfer(input string tag);
    chk({tag, "_done_low_at_stop"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles, input logic exp_done);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== exp_done) bad++;
    end
    chk({tag, "_quiet"}, 32'(bad), 32'd0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NW; i++) mem[i] = 12'($urandom_range(0, 4095));
  endtask

  initial begin
    int waited;
    n_pass = 0; n_total = 0;
    rst = 1'b1; fsm_state = 3'd0;
    mem[0] = 12'hABC; mem[1] = 12'h123; mem[2] = 12'hFFF;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    rst = 1'b0;

    // basic transfer, 4 -> 5
    fsm_state = 3'd4;
    repeat (2) @(negedge clk);
    fsm_state = 3'd5;
    do_xfer("basic", 2 * NW + 1, -1);
    end_of_xfer("basic");
    quiet("hold", 1000, 1'b1);
    fsm_state = 3'd0;
    @(negedge clk);
    chk("leave_done", 32'(done), 32'd0);

    // abort during the third byte, then re-entry
    fsm_state = 3'd5;
    do_xfer("abort", 3, 2);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    quiet("abort", 100, 1'b0);
    fsm_state = 3'd5;
    do_xfer("reentry", 2 * NW + 1, -1);
    end_of_xfer("reentry");
    fsm_state = 3'd0;
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of a data bit
    randomize_mem();
    mem[1][8] = 1'b0;
    fsm_state = 3'd5;
    do_xfer("pre_rst", 2, -1);
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_wait", 32'(waited < 50), 32'd1);
    repeat (BD + 2) @(negedge clk);
    chk("mid_bit_low", 32'(uart_tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_tx", 32'(uart_tx), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_addr", 32'(bram_addr), 32'd0);
    fsm_state = 3'd4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet("post_rst", 200, 1'b0);
    randomize_mem();
    fsm_state = 3'd5;
    do_xfer("fresh", 2 * NW + 1, -1);
    end_of_xfer("fresh");
    fsm_state = 3'd0;
    repeat (2) @(negedge clk);

    // state 5 held through reset release: exactly one transfer
    randomize_mem();
    fsm_state = 3'd5;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_xfer("held5", 2 * NW + 1, -1);
    end_of_xfer("held5");
    quiet("held5_once", 300, 1'b1);
    fsm_state = 3'd0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
